// File: rtl/mux_seq8.sv
// mux_seq8: serialises one byte through an external 8:1 mux.
// The byte is held on d, and the select s steps through the eight bit
// positions, either LSB first or MSB first. Each bit is handed over with a
// valid/ready handshake. abort cancels the byte in progress.
// byte_cnt counts the bytes that were sent completely.
// Every output is decoded from registered state only.
module mux_seq8 #(
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       abort,
  input  logic       bit_ready,
  output logic [7:0] d,
  output logic [2:0] s,
  output logic       bit_valid,
  output logic       last,
  output logic       busy,
  output logic [7:0] byte_cnt
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  localparam logic [2:0] SEL_FIRST = MSB_FIRST ? 3'd7 : 3'd0;

  // Select value for the next bit position in the configured order.
  function automatic logic [2:0] f_step_sel(input logic [2:0] sel);
    if (MSB_FIRST) begin
      f_step_sel = sel - 3'd1;
    end else begin
      f_step_sel = sel + 3'd1;
    end
  endfunction

  logic [0:0] r_state;
  logic [7:0] r_d;
  logic [2:0] r_s;
  logic [2:0] r_pos;
  logic [7:0] r_cnt;
  logic       r_live;   // low until the first edge after reset release

  logic [0:0] w_state_nxt;
  logic [7:0] w_d_nxt;
  logic [2:0] w_s_nxt;
  logic [2:0] w_pos_nxt;
  logic [7:0] w_cnt_nxt;
  logic       w_idle;
  logic       w_shift;
  logic       w_last;
  logic       w_accept;
  logic       w_xfer;

  assign w_idle   = (r_state == ST_IDLE);
  assign w_shift  = (r_state == ST_SHIFT);
  assign w_last   = w_shift && (r_pos == 3'd7);
  assign w_accept = w_idle && r_live && in_valid && !abort;
  assign w_xfer   = w_shift && bit_ready;

  // Next-state decode: accept in IDLE; in SHIFT, abort first, then transfer.
  always_comb begin
    w_state_nxt = r_state;
    w_d_nxt     = r_d;
    w_s_nxt     = r_s;
    w_pos_nxt   = r_pos;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_nxt = ST_SHIFT;
          w_d_nxt     = in_data;
          w_s_nxt     = SEL_FIRST;
          w_pos_nxt   = 3'd0;
        end else begin
          w_s_nxt     = 3'd0;
        end
      end
      ST_SHIFT: begin
        if (abort) begin
          // Abort wins even over a last-bit transfer: the byte is not counted.
          w_state_nxt = ST_IDLE;
          w_s_nxt     = 3'd0;
          w_pos_nxt   = 3'd0;
        end else if (w_xfer && w_last) begin
          w_state_nxt = ST_IDLE;
          w_s_nxt     = 3'd0;
          w_pos_nxt   = 3'd0;
          w_cnt_nxt   = r_cnt + 8'd1;
        end else if (w_xfer) begin
          w_s_nxt     = f_step_sel(r_s);
          w_pos_nxt   = r_pos + 3'd1;
        end else begin
          w_state_nxt = r_state;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_s_nxt     = 3'd0;
        w_pos_nxt   = 3'd0;
      end
    endcase
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_d     <= 8'd0;
      r_s     <= 3'd0;
      r_pos   <= 3'd0;
      r_cnt   <= 8'd0;
      r_live  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_d     <= w_d_nxt;
      r_s     <= w_s_nxt;
      r_pos   <= w_pos_nxt;
      r_cnt   <= w_cnt_nxt;
      r_live  <= 1'b1;
    end
  end

  assign in_ready  = r_live && w_idle;
  assign busy      = w_shift;
  assign bit_valid = w_shift;
  assign last      = w_last;
  assign d         = r_d;
  assign s         = r_s;
  assign byte_cnt  = r_cnt;

endmodule
